// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow sig_in
// in clock_in cycles, with lock and stall status.
`timescale 1ns/1ps

module clock_period_meter #(
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT     = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 stalled
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED
  } state_t;

  localparam int GW = $clog2(SYNC_STAGES + 2);
  localparam logic [GW-1:0] GUARD_END = GW'(SYNC_STAGES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] TO_CNT = CNT_WIDTH'(TIMEOUT);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic [GW-1:0]          guard;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   hi_cap;

  logic sync;
  logic edge_en;
  logic rise_det;
  logic fall_det;
  logic timeout;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign edge_en  = (guard == GUARD_END);
  assign rise_det = edge_en & sync & ~dly_q;
  assign fall_det = edge_en & ~sync & dly_q;
  assign timeout  = (cnt >= TO_CNT) & ~rise_det;

  // Synchronize sig_in and keep one delayed copy for edge detection.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      dly_q  <= sync;
    end
  end

  // Hold off edge detection until the synchronizer holds real samples.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      guard <= '0;
    end else if (guard != GUARD_END) begin
      guard <= guard + 1'b1;
    end
  end

  // Cycles since the last rise; saturates instead of wrapping.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise_det) begin
      cnt <= CNT_WIDTH'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Remember how long sig_in stayed high after the last rise.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      hi_cap <= '0;
    end else if (fall_det) begin
      hi_cap <= cnt;
    end
  end

  // Lock/stall FSM with registered measurement outputs.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (timeout) begin
        stalled <= 1'b1;
        locked  <= 1'b0;
        state   <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise_det) begin
              stalled <= 1'b0;
              state   <= ARMED;
            end
          end
          ARMED: begin
            if (rise_det) begin
              period       <= cnt;
              high_time    <= hi_cap;
              period_valid <= 1'b1;
              locked       <= 1'b1;
              state        <= LOCKED;
            end
          end
          LOCKED: begin
            if (rise_det) begin
              period       <= cnt;
              high_time    <= hi_cap;
              period_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: event-level reference model feeding a
// scoreboard queue; a negedge monitor compares every cycle.
`timescale 1ns/1ps

module tb_clock_period_meter;

  localparam int CW = 32;
  localparam int TO = 64;
  localparam int SS = 2;

  logic          clock_in = 1'b0;
  logic          reset = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          locked;
  logic          stalled;

  clock_period_meter #(
    .CNT_WIDTH(CW),
    .TIMEOUT(TO),
    .SYNC_STAGES(SS)
  ) dut (
    .clock_in(clock_in),
    .reset(reset),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .locked(locked),
    .stalled(stalled)
  );

  always #10 clock_in = ~clock_in;

  typedef enum int {EV_RISE1, EV_VALID, EV_STALL} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       at;
    int       per;
    int       hi;
  } ev_t;

  ev_t evq[$];
  int  edge_n = 0;
  int  checks = 0;
  int  passes = 0;

  // Clock edges counted from reset release.
  always @(posedge clock_in or posedge reset) begin
    if (reset) edge_n <= 0;
    else edge_n <= edge_n + 1;
  end

  // Reference model: works on sampled sig_in transitions, edges
  // expressed as the clock edge where the output reacts.
  bit m_prev;
  int m_phase;
  int m_ref;
  int m_hi;

  task automatic model_step(input int n, input bit v);
    int e;
    bit rise;
    bit fall;
    e = n + SS;
    if (n == 1) begin
      m_prev  = v;
      m_ref   = 1;
      m_phase = 0;
      m_hi    = 0;
      return;
    end
    rise = v & ~m_prev;
    fall = ~v & m_prev;
    m_prev = v;
    if (rise) begin
      if (m_phase == 0) begin
        evq.push_back('{EV_RISE1, e, 0, 0});
        m_phase = 1;
      end else begin
        evq.push_back('{EV_VALID, e, e - m_ref, m_hi});
        m_phase = 2;
      end
      m_ref = e;
    end else begin
      if (fall) m_hi = e - m_ref;
      if (e == m_ref + TO) begin
        evq.push_back('{EV_STALL, e, 0, 0});
        m_phase = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clock_in or posedge reset);
      if (reset) evq.delete();
      else model_step(edge_n + 1, sig_in);
    end
  end

  // Monitor: apply expected events due at this edge, then compare.
  initial begin
    logic [CW-1:0] x_period;
    logic [CW-1:0] x_high;
    bit            x_valid;
    bit            x_locked;
    bit            x_stalled;
    ev_t           ev;
    x_period  = '0;
    x_high    = '0;
    x_locked  = 1'b0;
    x_stalled = 1'b0;
    forever begin
      @(negedge clock_in);
      x_valid = 1'b0;
      if (reset) begin
        x_period  = '0;
        x_high    = '0;
        x_locked  = 1'b0;
        x_stalled = 1'b0;
      end else begin
        while (evq.size() > 0 && evq[0].at <= edge_n) begin
          ev = evq.pop_front();
          case (ev.kind)
            EV_RISE1: x_stalled = 1'b0;
            EV_VALID: begin
              x_valid  = 1'b1;
              x_period = CW'(ev.per);
              x_high   = CW'(ev.hi);
              x_locked = 1'b1;
            end
            default: begin
              x_stalled = 1'b1;
              x_locked  = 1'b0;
            end
          endcase
        end
      end
      checks++;
      if (period === x_period && high_time === x_high &&
          period_valid === x_valid && locked === x_locked &&
          stalled === x_stalled) begin
        passes++;
      end else begin
        $display("FAIL %s edge %0d: got per=%0d hi=%0d v=%b lk=%b st=%b want per=%0d hi=%0d v=%b lk=%b st=%b",
                 reset ? "in_reset" : "run", edge_n, period, high_time,
                 period_valid, locked, stalled, x_period, x_high,
                 x_valid, x_locked, x_stalled);
      end
    end
  end

  task automatic cyc(input bit v, input int n);
    @(negedge clock_in);
    sig_in = v;
    repeat (n - 1) @(negedge clock_in);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      cyc(1'b1, hi);
      cyc(1'b0, lo);
    end
  endtask

  task automatic release_reset();
    @(posedge clock_in);
    #5;
    reset = 1'b0;
  endtask

  task automatic async_reset_check();
    @(posedge clock_in);
    #5;
    reset = 1'b1;
    #1;
    checks++;
    if (period == '0 && high_time == '0 && !period_valid &&
        !locked && !stalled) begin
      passes++;
    end else begin
      $display("FAIL async_reset: got per=%0d hi=%0d v=%b lk=%b st=%b want all zero",
               period, high_time, period_valid, locked, stalled);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (10) begin
      @(negedge clock_in);
      sig_in = 1'($urandom_range(0, 1));
    end
    @(negedge clock_in);
    sig_in = 1'b1;
    release_reset();
    cyc(1'b1, 4);
    cyc(1'b0, 5);
    wave(5, 5, 6);
    wave(3, 9, 4);
    repeat (10) begin
      wave(int'($urandom_range(2, 20)), int'($urandom_range(2, 30)), 1);
    end
    wave(5, 5, 3);
    cyc(1'b0, 80);
    wave(5, 5, 4);
    wave(32, 32, 4);
    wave(33, 33, 3);
    wave(5, 5, 4);
    cyc(1'b1, 2);
    async_reset_check();
    repeat (3) @(negedge clock_in);
    sig_in = 1'b0;
    release_reset();
    cyc(1'b0, 3);
    wave(5, 5, 5);
    @(posedge clock_in);
    #5;
    reset = 1'b1;
    repeat (2) @(negedge clock_in);
    sig_in = 1'b0;
    release_reset();
    cyc(1'b0, 80);
    wave(5, 5, 3);
    cyc(1'b0, 10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
